// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the pipeline hazard/flush controller.
package pipe_ctrl_pkg;

  localparam logic RstEnable = 1'b0;
  localparam logic Stop      = 1'b1;

  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  localparam logic [31:0] ERET_CODE_DFLT  = 32'h0000_000E;
  localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0000_0020;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline/PC unit and the hazard/flush controller.
interface pipe_ctrl_if #(
  parameter int NUM_STAGES = 6
);
  logic [NUM_STAGES-1:0] stallreq;
  logic                  exc_valid;
  logic [31:0]           exc_type;
  logic [31:0]           epc;
  logic [NUM_STAGES-1:0] stall;
  logic                  flush;
  logic [31:0]           new_pc;
  logic [31:0]           stall_cycles;
  logic                  stall_timeout;

  modport master (
    output stallreq, exc_valid, exc_type, epc,
    input  stall, flush, new_pc, stall_cycles, stall_timeout
  );

  modport slave (
    input  stallreq, exc_valid, exc_type, epc,
    output stall, flush, new_pc, stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl_stall_decode.sv
// Converts per-stage stall requests into a thermometer stall vector: the highest
// requesting stage and every stage below it are held.
module pipe_ctrl_stall_decode #(
  parameter int NUM_STAGES = 6
) (
  input  logic [NUM_STAGES-1:0] stallreq,
  output logic [NUM_STAGES-1:0] stall
);

  always_comb begin
    logic seen;
    seen  = 1'b0;
    stall = '0;
    // Scan from the oldest stage downward; once a request is seen, everything younger holds.
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      seen     = seen | stallreq[i];
      stall[i] = seen;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and flush controller: stall thermometer, exception/ERET flush
// sequencing with redirect PC, stall-cycle counter and stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          NUM_STAGES    = 6,
  parameter int          FLUSH_CYCLES  = 1,
  parameter int          STALL_TIMEOUT = 1024,
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DFLT,
  parameter logic [31:0] ERET_CODE     = ERET_CODE_DFLT
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  fcnt_q, fcnt_n;
  logic [31:0]       pc_q, pc_n;
  logic [31:0]       exc_pc;
  logic [31:0]       cycles_q;
  logic [RUN_W-1:0]  run_q;
  logic              timeout_q;
  logic              flush;
  logic [31:0]       new_pc;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] stall;
  logic              stalled;

  pipe_ctrl_stall_decode #(
    .NUM_STAGES(NUM_STAGES)
  ) u_stall_decode (
    .stallreq(bus.stallreq),
    .stall   (stall_raw)
  );

  assign exc_pc = (bus.exc_type == ERET_CODE) ? bus.epc : EXC_VECTOR;

  always_comb begin
    state_n = state_q;
    fcnt_n  = fcnt_q;
    pc_n    = pc_q;
    flush   = 1'b0;
    new_pc  = 32'd0;
    if (rst != RstEnable) begin
      case (state_q)
        IDLE: begin
          if (bus.exc_valid) begin
            flush  = 1'b1;
            new_pc = exc_pc;
            pc_n   = exc_pc;
            if (FLUSH_CYCLES > 1) begin
              state_n = FLUSH;
              fcnt_n  = CNT_W'(FLUSH_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          // Further exceptions are dropped: the pipeline is already being cleared.
          flush  = 1'b1;
          new_pc = pc_q;
          fcnt_n = fcnt_q - CNT_W'(1);
          if (fcnt_q == CNT_W'(1)) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Reset and flush both override stall requests.
  assign stall   = ((rst == RstEnable) || flush) ? '0 : stall_raw;
  assign stalled = |stall;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= IDLE;
      fcnt_q    <= '0;
      pc_q      <= 32'd0;
      cycles_q  <= 32'd0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_n;
      fcnt_q  <= fcnt_n;
      pc_q    <= pc_n;
      if (stalled) cycles_q <= sat_inc32(cycles_q);
      if (!stalled || flush) begin
        run_q <= '0;
      end else if (run_q != RUN_W'(STALL_TIMEOUT)) begin
        run_q <= run_q + RUN_W'(1);
      end
      if (stalled && (run_q == RUN_W'(STALL_TIMEOUT - 1))) timeout_q <= Stop;
    end
  end

  assign bus.stall         = stall;
  assign bus.flush         = flush;
  assign bus.new_pc        = new_pc;
  assign bus.stall_cycles  = cycles_q;
  assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with FLUSH_CYCLES=3 and STALL_TIMEOUT=4.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errs;

  pipe_ctrl_if #(.NUM_STAGES(6)) bus ();

  pipe_ctrl #(
    .NUM_STAGES   (6),
    .FLUSH_CYCLES (3),
    .STALL_TIMEOUT(4),
    .EXC_VECTOR   (32'h0000_0020),
    .ERET_CODE    (32'h0000_000E)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, settle, then the caller checks.
  task automatic cyc(input logic r, input logic [5:0] sreq, input logic ev,
                     input logic [31:0] typ, input logic [31:0] pc);
    @(negedge clk);
    rst           = r;
    bus.stallreq  = sreq;
    bus.exc_valid = ev;
    bus.exc_type  = typ;
    bus.epc       = pc;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst           = 1'b0;
    bus.stallreq  = '0;
    bus.exc_valid = 1'b0;
    bus.exc_type  = '0;
    bus.epc       = '0;

    // Reset dominates everything
    cyc(0, 6'b111111, 1, 32'h4, 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    cyc(0, 6'b111111, 1, 32'h4, 32'h0);
    chk("rst_cycles", bus.stall_cycles, 32'h0);
    chk("rst_timeout", 32'(bus.stall_timeout), 32'h0);
    chk("rst_newpc", bus.new_pc, 32'h0);

    // Thermometer mapping, 0-cycle latency
    cyc(1, 6'b000100, 0, 32'h0, 32'h0);
    chk("map_id", 32'(bus.stall), 32'h07);
    chk("map_cyc0", bus.stall_cycles, 32'd0);
    cyc(1, 6'b001100, 0, 32'h0, 32'h0);
    chk("map_ex_id", 32'(bus.stall), 32'h0F);
    chk("map_cyc1", bus.stall_cycles, 32'd1);
    cyc(1, 6'b000001, 0, 32'h0, 32'h0);
    chk("map_pc", 32'(bus.stall), 32'h01);
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("map_none", 32'(bus.stall), 32'h00);
    chk("map_cyc3", bus.stall_cycles, 32'd3);
    chk("run3_no_to", 32'(bus.stall_timeout), 32'h0);

    // Second run of 3 stalls after one free cycle
    for (int i = 0; i < 3; i++) cyc(1, 6'b000100, 0, 32'h0, 32'h0);
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("run3b_no_to", 32'(bus.stall_timeout), 32'h0);
    chk("run3b_cyc", bus.stall_cycles, 32'd6);

    // Exception beats a simultaneous stall; flush held 3 cycles
    cyc(1, 6'b000100, 1, 32'h4, 32'h1234_5678);
    chk("exc_flush0", 32'(bus.flush), 32'h1);
    chk("exc_stall0", 32'(bus.stall), 32'h0);
    chk("exc_pc0", bus.new_pc, 32'h20);
    cyc(1, 6'b000100, 0, 32'h0, 32'h0);
    chk("exc_flush1", 32'(bus.flush), 32'h1);
    chk("exc_stall1", 32'(bus.stall), 32'h0);
    chk("exc_pc1", bus.new_pc, 32'h20);
    cyc(1, 6'b000000, 1, 32'hE, 32'hBFC0_0100);
    chk("exc_flush2", 32'(bus.flush), 32'h1);
    chk("exc_ignored", bus.new_pc, 32'h20);
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("exc_flush3", 32'(bus.flush), 32'h0);
    chk("exc_pc3", bus.new_pc, 32'h0);
    chk("exc_cyc", bus.stall_cycles, 32'd6);

    // ERET redirects to epc
    cyc(1, 6'b000000, 1, 32'hE, 32'hBFC0_0100);
    chk("eret_flush0", 32'(bus.flush), 32'h1);
    chk("eret_pc0", bus.new_pc, 32'hBFC0_0100);
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("eret_pc1", bus.new_pc, 32'hBFC0_0100);
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("eret_flush2", 32'(bus.flush), 32'h1);
    chk("eret_pc2", bus.new_pc, 32'hBFC0_0100);
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("eret_flush3", 32'(bus.flush), 32'h0);
    chk("eret_pc3", bus.new_pc, 32'h0);

    // Watchdog: sets on the 4th consecutive stalled edge, then sticky
    for (int i = 0; i < 4; i++) begin
      cyc(1, 6'b000100, 0, 32'h0, 32'h0);
      chk("wd_pre", 32'(bus.stall_timeout), 32'h0);
    end
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("wd_set", 32'(bus.stall_timeout), 32'h1);
    chk("wd_cyc", bus.stall_cycles, 32'd10);
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("wd_sticky", 32'(bus.stall_timeout), 32'h1);

    // Counter saturation
    @(negedge clk);
    force dut.cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycles_q;
    bus.stallreq = 6'b000100;
    #1;
    chk("sat_pre", bus.stall_cycles, 32'hFFFF_FFFE);
    cyc(1, 6'b000100, 0, 32'h0, 32'h0);
    chk("sat_max", bus.stall_cycles, 32'hFFFF_FFFF);
    cyc(1, 6'b000100, 0, 32'h0, 32'h0);
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("sat_nowrap", bus.stall_cycles, 32'hFFFF_FFFF);

    // Reset in the middle of a flush
    cyc(1, 6'b000000, 1, 32'h4, 32'h0);
    chk("mid_flush", 32'(bus.flush), 32'h1);
    cyc(0, 6'b000100, 0, 32'h0, 32'h0);
    chk("mid_rst_flush", 32'(bus.flush), 32'h0);
    chk("mid_rst_pc", bus.new_pc, 32'h0);
    chk("mid_rst_stall", 32'(bus.stall), 32'h0);
    cyc(0, 6'b000000, 0, 32'h0, 32'h0);
    chk("mid_rst_cyc", bus.stall_cycles, 32'h0);
    chk("mid_rst_to", 32'(bus.stall_timeout), 32'h0);
    cyc(1, 6'b000000, 0, 32'h0, 32'h0);
    chk("post_rst_idle", 32'(bus.flush), 32'h0);
    chk("post_rst_pc", bus.new_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline hazard and flush controller for the MIPS core.
- Accepts one stall request per pipeline stage and drives a per-stage stall vector.
- Accepts an exception/ERET event from the memory stage and drives a multi-cycle flush with a redirect PC.
- Keeps a saturating stall-cycle performance counter and a sticky stall-timeout watchdog.
- Sits beside the pipeline registers and the PC unit; replaces the single-source stall controller.

Parameters:
- NUM_STAGES, 6, number of stall bits; bit 0 = PC, bit 1 = IF, bit 2 = ID, bit 3 = EX, bit 4 = MEM, bit 5 = WB.
- FLUSH_CYCLES, 1, total cycles flush is held per accepted event; must be >= 1.
- STALL_TIMEOUT, 1024, consecutive stalled cycles before stall_timeout sets; must be >= 2.
- EXC_VECTOR, 32'h0000_0020, redirect PC for non-ERET exceptions.
- ERET_CODE, 32'h0000_000E, exc_type value that selects epc as the redirect PC.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low: rst==0 resets on the rising edge of clk.
- stallreq  in  NUM_STAGES  bit i = stage i requests a stall.
- exc_valid  in  1  one-cycle exception/ERET event.
- exc_type  in  32  exception code, sampled with exc_valid.
- epc  in  32  return address, sampled with exc_valid.
- stall  out  NUM_STAGES  per-stage stall; 1 = hold that stage.
- flush  out  1  clear all pipeline registers.
- new_pc  out  32  redirect PC, valid while flush==1.
- stall_cycles  out  32  saturating count of cycles with stall != 0.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst==0 at a clk edge): FSM goes to IDLE, flush counter = 0, stall_cycles = 0, stall_timeout = 0, consecutive-stall counter = 0, new_pc register = 0.
- While rst==0, stall = 0 and flush = 0 combinationally.
- Stall mapping is combinational with 0-cycle latency. Let h be the highest index i with stallreq[i] == 1. Then stall = bits [h:0] set and all higher bits clear. No request gives stall = 0.
  - Example: a request from ID only gives 6'b000111.
- FSM states are IDLE and FLUSH.
  - IDLE with exc_valid == 1: flush = 1 in the same cycle.
    - new_pc = epc when exc_type == ERET_CODE, otherwise EXC_VECTOR. It is driven combinationally in this cycle and registered for later cycles.
    - If FLUSH_CYCLES > 1: go to FLUSH with counter = FLUSH_CYCLES-1.
  - FLUSH: flush = 1 and new_pc = the registered value. Counter decrements each cycle; when counter == 1, go to IDLE next cycle.
  - exc_valid while in FLUSH is ignored, because the pipeline is being cleared.
- Priority: reset > flush > stall.
  - Whenever flush == 1, stall = 0 regardless of stallreq.
  - When flush == 0, new_pc = 0.
- stall_cycles increments by 1 on each edge where the registered-cycle stall != 0. It saturates at 32'hFFFF_FFFF and never wraps.
- Consecutive-stall counter:
  - Increments when stall != 0; clears when stall == 0 or flush == 1. It saturates at STALL_TIMEOUT.
  - stall_timeout sets on the edge where the counter reaches STALL_TIMEOUT, i.e. the STALL_TIMEOUT-th consecutive stalled cycle.
  - stall_timeout clears only on reset.
- Reset mid-flush: the FSM returns to IDLE and flush drops in the cycle rst is sampled low.

Decomposition:
- Shared defines header gets: RstEnable (1'b0), Stop (1'b1), stage index constants (STAGE_PC..STAGE_WB), ERET_CODE, EXC_VECTOR default.
- One natural sub-module: stall_decode. It is a pure function converting stallreq to the thermometer stall vector via priority scan, reusable for variants with other NUM_STAGES values.
- Counters and FSM stay in pipe_ctrl.

Test Plan (defaults unless stated):
- Reset: hold rst=0 with stallreq=6'b111111 and exc_valid=1 -> stall=0, flush=0, stall_cycles=0, stall_timeout=0.
- Mapping: stallreq=6'b000100 -> stall=6'b000111. Then stallreq=6'b001100 -> stall=6'b001111. Then stallreq=6'b000001 -> stall=6'b000001. Each has 0-cycle latency.
- Exception vs stall: exc_valid=1, exc_type=32'h4, stallreq=6'b000100 in the same cycle -> flush=1, stall=0, new_pc=32'h20. With FLUSH_CYCLES=3, flush stays high for exactly 3 cycles and an exc_valid in cycle 2 is ignored.
- ERET: exc_type=32'hE, epc=32'hBFC0_0100 -> new_pc=32'hBFC0_0100 while flush=1. new_pc returns to 0 after flush drops.
- Watchdog: STALL_TIMEOUT=4 with stallreq=6'b000100 held -> stall_timeout rises on the 4th stalled edge and stays 1 after stallreq drops. Stalls of length 3 separated by one free cycle never set it.
- Counter saturation: force stall_cycles to 32'hFFFF_FFFE, then stall for 3 cycles -> reads 32'hFFFF_FFFF and does not wrap.
